writeback_stage: RTL and testbench

Final stage of the ARC MIPS pipeline. It accepts retiring instructions from the MEM stage over a valid/ready handshake. Loads wait for the data-memory response, which can take several cycles. Load data is extracted by byte lane and sign- or zero-extended. The stage drives the register-bank write port of the decode stage (RegWr, write address, write data) as a registered, single-cycle pulse.

---
 rtl/writeback_stage.sv | 149 ++++++++++++++
 tb/tb_writeback_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU results immediately, and waits for the data-memory response on loads.
// Optional WB_BYPASS_EN adds combinational forwarding of the value about to be written.
module writeback_stage #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_mem_valid,
  output logic             o_mem_ready,
  input  logic             i_con_RegWr,
  input  logic             i_con_MemToReg,
  input  logic [1:0]       i_con_LoadSize,
  input  logic             i_con_LoadSigned,
  input  logic [4:0]       i_addr_WrReg,
  input  logic [31:0]      i_data_AluResult,
  input  logic             i_dmem_rvalid,
  input  logic [31:0]      i_dmem_rdata,
  output logic             o_con_RegWr,
  output logic [4:0]       o_addr_WrReg,
  output logic [31:0]      o_data_WrData,
  output logic             o_stall,
  output logic             o_err_timeout,
  output logic [CNT_W-1:0] o_cnt_retired,
  output logic             dbg_state
`ifdef WB_BYPASS_EN
  ,
  output logic             o_fwd_valid,
  output logic [4:0]       o_fwd_addr,
  output logic [31:0]      o_fwd_data
`endif
);

  // Handshake: an instruction transfers on any cycle where i_mem_valid && o_mem_ready;
  // o_mem_ready depends only on state, never on i_mem_valid.
  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              lat_regwr_q, lat_signed_q;
  logic [1:0]        lat_size_q, lat_off_q;
  logic [4:0]        lat_dest_q;
  logic              capture, wr_en, retire, timeout;
  logic [4:0]        wr_addr;
  logic [31:0]       wr_data, load_data;

  function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [1:0] size,
                                          input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[8*off +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b10:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    capture     = 1'b0;
    wr_en       = 1'b0;
    retire      = 1'b0;
    timeout     = 1'b0;
    wr_addr     = i_addr_WrReg;
    wr_data     = i_data_AluResult;
    load_data   = extract(i_dmem_rdata, lat_size_q, lat_off_q, lat_signed_q);
    o_mem_ready = (state_q == S_IDLE);
    o_stall     = (state_q == S_WAIT);
    case (state_q)
      S_IDLE: begin
        if (i_mem_valid) begin
          if (i_con_MemToReg) begin
            capture = 1'b1;
            state_d = S_WAIT;
          end else begin
            retire = 1'b1;
            wr_en  = i_con_RegWr && (i_addr_WrReg != 5'd0);
          end
        end
      end
      S_WAIT: begin
        wr_addr = lat_dest_q;
        wr_data = load_data;
        // A response on the final wait cycle still completes the load.
        if (i_dmem_rvalid) begin
          retire  = 1'b1;
          wr_en   = lat_regwr_q && (lat_dest_q != 5'd0);
          state_d = S_IDLE;
        end else if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      wait_q        <= '0;
      lat_regwr_q   <= 1'b0;
      lat_signed_q  <= 1'b0;
      lat_size_q    <= 2'b00;
      lat_off_q     <= 2'b00;
      lat_dest_q    <= 5'd0;
      o_con_RegWr   <= 1'b0;
      o_addr_WrReg  <= 5'd0;
      o_data_WrData <= 32'd0;
      o_err_timeout <= 1'b0;
      o_cnt_retired <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      o_con_RegWr <= wr_en;
      if (capture) begin
        lat_regwr_q  <= i_con_RegWr;
        lat_signed_q <= i_con_LoadSigned;
        lat_size_q   <= i_con_LoadSize;
        lat_off_q    <= i_data_AluResult[1:0];
        lat_dest_q   <= i_addr_WrReg;
      end
      if (wr_en) begin
        o_addr_WrReg  <= wr_addr;
        o_data_WrData <= wr_data;
      end
      if (retire)  o_cnt_retired <= o_cnt_retired + CNT_W'(1);
      if (timeout) o_err_timeout <= 1'b1;
    end
  end

  assign dbg_state = state_q;

`ifdef WB_BYPASS_EN
  assign o_fwd_valid = wr_en;
  assign o_fwd_addr  = wr_addr;
  assign o_fwd_data  = wr_data;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: ALU retire, load extraction, timeout, reset and counter wrap.
module tb_writeback_stage;

  localparam int MAX_WAIT = 16;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_valid, mem_ready;
  logic             con_regwr, con_memtoreg, con_signed;
  logic [1:0]       con_size;
  logic [4:0]       addr_wrreg;
  logic [31:0]      alu_result;
  logic             dmem_rvalid;
  logic [31:0]      dmem_rdata;
  logic             o_regwr;
  logic [4:0]       o_addr;
  logic [31:0]      o_data;
  logic             stall, err_timeout, dbg_state;
  logic [CNT_W-1:0] cnt_retired;
`ifdef WB_BYPASS_EN
  logic             fwd_valid;
  logic [4:0]       fwd_addr;
  logic [31:0]      fwd_data;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  logic [4:0]  last_addr = 5'd0;
  logic [31:0] last_data = 32'd0;
  logic [36:0] exp_q[$];

  writeback_stage #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_mem_valid(mem_valid), .o_mem_ready(mem_ready),
    .i_con_RegWr(con_regwr), .i_con_MemToReg(con_memtoreg),
    .i_con_LoadSize(con_size), .i_con_LoadSigned(con_signed),
    .i_addr_WrReg(addr_wrreg), .i_data_AluResult(alu_result),
    .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
    .o_con_RegWr(o_regwr), .o_addr_WrReg(o_addr), .o_data_WrData(o_data),
    .o_stall(stall), .o_err_timeout(err_timeout), .o_cnt_retired(cnt_retired),
    .dbg_state(dbg_state)
`ifdef WB_BYPASS_EN
    , .o_fwd_valid(fwd_valid), .o_fwd_addr(fwd_addr), .o_fwd_data(fwd_data)
`endif
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write pulse must match the next expected {addr,data}
  always @(negedge clk) begin
    if (o_regwr === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_write", {o_addr, o_data}, 64'h0);
      else check("wr_port", {o_addr, o_data}, exp_q.pop_front());
    end
  end

  task automatic check_outputs(input string tag, input logic exp_wr);
    check({tag, "_regwr"}, o_regwr, exp_wr);
    check({tag, "_addr"}, o_addr, last_addr);
    check({tag, "_data"}, o_data, last_data);
    check({tag, "_cnt"}, cnt_retired, exp_cnt[CNT_W-1:0]);
  endtask

  task automatic alu_op(input logic regwr, input logic [4:0] dest, input logic [31:0] data);
    logic exp_wr;
    mem_valid = 1'b1; con_regwr = regwr; con_memtoreg = 1'b0;
    con_size = 2'b00; con_signed = 1'b0; addr_wrreg = dest; alu_result = data;
    check("alu_ready", mem_ready, 1'b1);
    exp_wr = regwr && (dest != 5'd0);
    if (exp_wr) begin
      exp_q.push_back({dest, data});
      last_addr = dest;
      last_data = data;
    end
    exp_cnt++;
    step();
    mem_valid = 1'b0;
    check_outputs("alu", exp_wr);
  endtask

  task automatic load_op(input logic regwr, input logic [4:0] dest, input logic [31:0] ea,
                         input logic [1:0] size, input logic sgn, input logic [31:0] rdata,
                         input int delay, input logic [31:0] exp_data);
    logic exp_wr;
    mem_valid = 1'b1; con_regwr = regwr; con_memtoreg = 1'b1;
    con_size = size; con_signed = sgn; addr_wrreg = dest; alu_result = ea;
    check("ld_ready", mem_ready, 1'b1);
    step();
    mem_valid = 1'b0; addr_wrreg = 5'd31; alu_result = 32'hFFFF_FFFF; con_size = 2'b11;
    for (int i = 1; i <= delay; i++) begin
      check("ld_stall", stall, 1'b1);
      check("ld_not_ready", mem_ready, 1'b0);
      check("ld_no_early_wr", o_regwr, 1'b0);
      if (i == delay) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
      end
      step();
    end
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h5A5A_5A5A;
    exp_wr = regwr && (dest != 5'd0);
    if (exp_wr) begin
      exp_q.push_back({dest, exp_data});
      last_addr = dest;
      last_data = exp_data;
    end
    exp_cnt++;
    check_outputs("ld", exp_wr);
    check("ld_stall_done", stall, 1'b0);
  endtask

  task automatic idle_step();
    step();
    check("idle_regwr", o_regwr, 1'b0);
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; con_regwr = 1'b0; con_memtoreg = 1'b0;
    con_size = 2'b00; con_signed = 1'b0; addr_wrreg = 5'd0; alu_result = 32'd0;
    dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    step();
    step();
    check("rst_ready", mem_ready, 1'b1);
    check("rst_stall", stall, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    check_outputs("rst", 1'b0);
    rst = 1'b0;
    step();

    // ALU path, $0 suppression, RegWr=0, back-to-back ALU
    alu_op(1'b1, 5'd5, 32'h1234_5678);
    idle_step();
    alu_op(1'b1, 5'd0, 32'hDEAD_BEEF);
    alu_op(1'b0, 5'd7, 32'h0BAD_0BAD);
    alu_op(1'b1, 5'd9, 32'hA5A5_0001);
    idle_step();

    // Loads: byte/half/word extraction, sign and zero extension
    load_op(1'b1, 5'd6,  32'h0000_1003, 2'b10, 1'b1, 32'h80FF_0000, 4, 32'hFFFF_FF80);
    idle_step();
    load_op(1'b1, 5'd6,  32'h0000_1003, 2'b10, 1'b0, 32'h80FF_0000, 1, 32'h0000_0080);
    idle_step();
    load_op(1'b1, 5'd10, 32'h0000_2002, 2'b01, 1'b1, 32'h8001_1234, 2, 32'hFFFF_8001);
    idle_step();
    load_op(1'b1, 5'd11, 32'h0000_2001, 2'b01, 1'b1, 32'h8001_1234, 3, 32'h0000_1234);
    idle_step();
    load_op(1'b1, 5'd12, 32'h0000_3002, 2'b11, 1'b1, 32'hCAFE_F00D, 1, 32'hCAFE_F00D);
    idle_step();
    load_op(1'b1, 5'd13, 32'h0000_3001, 2'b00, 1'b1, 32'h8765_4321, 2, 32'h8765_4321);
    idle_step();
    load_op(1'b1, 5'd14, 32'h0000_4002, 2'b10, 1'b1, 32'h00A5_0000, 1, 32'hFFFF_FFA5);
    idle_step();
    load_op(1'b1, 5'd15, 32'h0000_4001, 2'b10, 1'b1, 32'h1122_3344, 1, 32'h0000_0033);
    idle_step();
    load_op(1'b1, 5'd0,  32'h0000_5000, 2'b00, 1'b0, 32'h1111_2222, 2, 32'h1111_2222);
    idle_step();
    // Response on the last permitted cycle beats the timeout, then an ALU op back-to-back
    load_op(1'b1, 5'd16, 32'h0000_6000, 2'b00, 1'b0, 32'h7777_8888, MAX_WAIT, 32'h7777_8888);
    check("rvalid_beats_timeout", err_timeout, 1'b0);
    alu_op(1'b1, 5'd17, 32'h0000_0042);
    idle_step();

    // Timeout with no response, then a stray rvalid in IDLE
    mem_valid = 1'b1; con_regwr = 1'b1; con_memtoreg = 1'b1; addr_wrreg = 5'd20;
    alu_result = 32'h0000_7000; con_size = 2'b00;
    step();
    mem_valid = 1'b0;
    for (int i = 1; i <= MAX_WAIT; i++) begin
      check("to_stall", stall, 1'b1);
      check("to_err_early", err_timeout, 1'b0);
      step();
    end
    check("to_err", err_timeout, 1'b1);
    check("to_ready", mem_ready, 1'b1);
    check_outputs("to", 1'b0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hBBBB_CCCC;
    step();
    dmem_rvalid = 1'b0;
    check_outputs("stray", 1'b0);
    alu_op(1'b1, 5'd21, 32'h0000_0021);
    check("err_sticky", err_timeout, 1'b1);
    idle_step();

    // Reset in the middle of a load, then a late rvalid
    mem_valid = 1'b1; con_regwr = 1'b1; con_memtoreg = 1'b1; addr_wrreg = 5'd22;
    alu_result = 32'h0000_8000;
    step();
    mem_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0; last_addr = 5'd0; last_data = 32'd0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h9999_9999;
    step();
    dmem_rvalid = 1'b0;
    check("mrst_err", err_timeout, 1'b0);
    check("mrst_stall", stall, 1'b0);
    check("mrst_ready", mem_ready, 1'b1);
    check_outputs("mrst", 1'b0);
    idle_step();

    // Retired counter wraps modulo 2^CNT_W
    for (int i = 0; i < (1 << CNT_W) - 1; i++) alu_op(1'b0, 5'd3, 32'(i));
    alu_op(1'b1, 5'd3, 32'h0000_0F0F);
    check("cnt_wrapped", cnt_retired, '0);
    idle_step();
    step();

    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
